// File: rtl/dbg_bus_ctrl_pkg.sv
// Shared definitions for the UART debug bus controller: host opcodes,
// controller state encoding and small helpers.
package dbg_defs;

  localparam logic [7:0] DBG_WR   = 8'h02;
  localparam logic [7:0] DBG_RD   = 8'h03;
  localparam logic [7:0] DBG_HOLD = 8'h06;
  localparam logic [7:0] DBG_RUN  = 8'h07;

  localparam int TMO_W = 21;
  localparam int LAT_W = 3;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    ACQUIRE,
    ACCESS,
    RD_WAIT,
    TX_SEND,
    TX_WAIT
  } dbg_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dbg_bus_ctrl.sv
// UART debug command parser and bus arbiter: accepts WRITE/READ/HOLD/RUN
// commands from the host, borrows the CPU bus and returns read data over UART.
module dbg_bus_ctrl
  import dbg_defs::*;
#(
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT     = 1048576,
  parameter bit          HOLD_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  output logic        cpu_hold,
  output logic        cpu_halt_req,
  input  logic        cpu_halt_ack,
  output logic        bus_sel,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  err_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  dbg_state_t       state_q, state_d;
  logic             is_wr_q;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       tx_data_q;
  logic             hold_q;
  logic [7:0]       err_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             tx_active_q;

  logic collecting, busy, known_op, tmo_hit, rd_done, tx_fall, err_evt;

  assign collecting = state_q inside {ADDR_HI, ADDR_LO, DATA};
  assign busy       = state_q inside {ACQUIRE, ACCESS, RD_WAIT, TX_SEND, TX_WAIT};
  assign known_op   = rx_data inside {DBG_WR, DBG_RD, DBG_HOLD, DBG_RUN};
  assign tmo_hit    = collecting && !rx_valid && (tmo_cnt_q == TMO_LAST);
  assign rd_done    = (state_q == RD_WAIT) && (lat_cnt_q == LAT_LAST);
  assign tx_fall    = tx_active_q && !tx_active;

  // Every way a command can go wrong funnels into one saturating counter.
  assign err_evt = (state_q == IDLE && rx_valid && !known_op)
                || tmo_hit
                || (busy && rx_valid);

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so the order of statements in this block cannot change behaviour.
    if (rst) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_data_q   <= '0;
      hold_q      <= HOLD_ON_RST;
      err_q       <= '0;
      tmo_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_active_q <= tx_active;

      if (err_evt) err_q <= sat_inc8(err_q);

      if (rx_valid || !collecting) tmo_cnt_q <= '0;
      else if (tmo_cnt_q != '1)    tmo_cnt_q <= tmo_cnt_q + 1'b1;

      if (state_q == RD_WAIT) lat_cnt_q <= lat_cnt_q + 1'b1;
      else                    lat_cnt_q <= '0;

      if (rd_done) tx_data_q <= bus_rdata;

      if (rx_valid) begin
        unique case (state_q)
          IDLE: begin
            if (rx_data == DBG_WR || rx_data == DBG_RD) is_wr_q <= (rx_data == DBG_WR);
            if (rx_data == DBG_HOLD) hold_q <= 1'b1;
            if (rx_data == DBG_RUN)  hold_q <= 1'b0;
          end
          ADDR_HI: addr_q[15:8] <= rx_data;
          ADDR_LO: addr_q[7:0]  <= rx_data;
          DATA:    wdata_q      <= rx_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: the default assignment up front is what keeps this block from
    // inferring a latch on paths that do not assign state_d.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_valid && (rx_data == DBG_WR || rx_data == DBG_RD)) state_d = ADDR_HI;
      ADDR_HI: if (rx_valid) state_d = ADDR_LO;
               else if (tmo_hit) state_d = IDLE;
      ADDR_LO: if (rx_valid) state_d = is_wr_q ? DATA : ACQUIRE;
               else if (tmo_hit) state_d = IDLE;
      DATA:    if (rx_valid) state_d = ACQUIRE;
               else if (tmo_hit) state_d = IDLE;
      ACQUIRE: if (hold_q || cpu_halt_ack) state_d = ACCESS;
      ACCESS:  state_d = is_wr_q ? IDLE : RD_WAIT;
      RD_WAIT: if (rd_done) state_d = TX_SEND;
      TX_SEND: if (!tx_active) state_d = TX_WAIT;
      TX_WAIT: if (tx_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset landing on ACCESS never reaches the bus.
  always_comb begin
    cpu_halt_req = 1'b0;
    bus_sel      = 1'b0;
    bus_we       = 1'b0;
    bus_re       = 1'b0;
    tx_start     = 1'b0;
    unique case (state_q)
      ACQUIRE: cpu_halt_req = !hold_q;
      ACCESS: begin
        cpu_halt_req = !hold_q;
        bus_sel      = 1'b1;
        bus_we       = is_wr_q && !rst;
        bus_re       = !is_wr_q && !rst;
      end
      RD_WAIT: begin
        cpu_halt_req = !hold_q;
        bus_sel      = 1'b1;
      end
      TX_SEND: tx_start = !tx_active && !rst;
      default: ;
    endcase
  end

  assign cpu_hold  = hold_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign tx_data   = tx_data_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_dbg_bus_ctrl.sv
// Scoreboard bench for dbg_bus_ctrl: stimulus pushes expected bus writes,
// bus reads and UART replies; independent monitors pop and compare them.
`timescale 1ns/1ps
module tb_dbg_bus_ctrl;

  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic        cpu_hold;
  logic        cpu_halt_req;
  logic        cpu_halt_ack = 1'b0;
  logic        bus_sel;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata = 8'h00;
  logic [7:0]  err_cnt;

  logic uart_busy = 1'b0;
  logic ext_busy  = 1'b0;
  assign tx_active = uart_busy | ext_busy;

  dbg_bus_ctrl #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .HOLD_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active),
    .cpu_hold(cpu_hold), .cpu_halt_req(cpu_halt_req), .cpu_halt_ack(cpu_halt_ack),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: what the host expects the target memory and controller to hold.
  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  mem_m   [logic [15:0]];
  logic [7:0]  env_mem [logic [15:0]];
  logic        hold_m = 1'b1;
  logic [7:0]  err_m  = 8'h00;

  function automatic logic [7:0] def_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    return mem_m.exists(a) ? mem_m[a] : def_val(a);
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Target memory: stores bus writes, answers reads RD_LAT cycles after bus_re.
  logic [7:0] rd_v;
  always begin
    @(negedge clk);
    if (bus_we) env_mem[bus_addr] = bus_wdata;
    if (bus_re) begin
      rd_v = env_mem.exists(bus_addr) ? env_mem[bus_addr] : def_val(bus_addr);
      repeat (RD_LAT) @(posedge clk);
      #1 bus_rdata = rd_v;
      @(posedge clk);
      #1 bus_rdata = ~rd_v;
    end
  end

  // CPU: acknowledges a halt request after ack_delay cycles, releases when req drops.
  int ack_delay = 0;
  always begin
    @(negedge clk);
    if (cpu_halt_req && !cpu_halt_ack) begin
      repeat (ack_delay + 1) @(posedge clk);
      #1 cpu_halt_ack = 1'b1;
      for (int n = 0; n < 1000 && cpu_halt_req; n++) @(negedge clk);
      cpu_halt_ack = 1'b0;
    end
  end

  // UART transmitter: busy for tx_busy_len cycles after each start.
  int tx_busy_len = 4;
  always begin
    @(negedge clk);
    if (tx_start) begin
      @(posedge clk);
      #1 uart_busy = 1'b1;
      repeat (tx_busy_len) @(posedge clk);
      #1 uart_busy = 1'b0;
    end
  end

  // Monitors.
  wr_t mon_w;
  always begin
    @(negedge clk);
    if (bus_we) begin
      if (exp_wr.size() == 0) check("unexpected_bus_we", 1, 0);
      else begin
        mon_w = exp_wr.pop_front();
        check("we_addr", bus_addr, mon_w.addr);
        check("we_data", bus_wdata, mon_w.data);
        check("we_sel", bus_sel, 1);
        check("we_bus_owned", cpu_hold | cpu_halt_ack, 1);
        check("we_halt_req", cpu_halt_req, !hold_m);
      end
      @(negedge clk);
      check("we_single_cycle", bus_we, 0);
      check("we_release_sel", bus_sel, 0);
      check("we_release_req", cpu_halt_req, 0);
    end
  end

  logic [15:0] mon_a;
  always begin
    @(negedge clk);
    if (bus_re) begin
      if (exp_rd.size() == 0) check("unexpected_bus_re", 1, 0);
      else begin
        mon_a = exp_rd.pop_front();
        check("re_addr", bus_addr, mon_a);
        check("re_sel", bus_sel, 1);
        check("re_bus_owned", cpu_hold | cpu_halt_ack, 1);
      end
    end
  end

  always begin
    @(negedge clk);
    if (tx_start) begin
      if (exp_tx.size() == 0) check("unexpected_tx_start", 1, 0);
      else check("tx_data", tx_data, exp_tx.pop_front());
      check("tx_start_while_busy", tx_active, 0);
      check("tx_bus_released", bus_sel | cpu_halt_req, 0);
    end
  end

  // Stimulus helpers.
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      check("response_timeout", n, 0);
      exp_wr.delete();
      exp_rd.delete();
      exp_tx.delete();
    end
    repeat (3) @(negedge clk);
    n = 0;
    while (tx_active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1 check("err_cnt_after_cmd", err_cnt, err_m);
  endtask

  task automatic issue_write(input logic [15:0] a, input logic [7:0] d);
    exp_wr.push_back('{addr: a, data: d});
    mem_m[a] = d;
    send_byte(8'h02, $urandom_range(0, 3));
    send_byte(a[15:8], $urandom_range(0, 3));
    send_byte(a[7:0], $urandom_range(0, 3));
    send_byte(d, 0);
  endtask

  task automatic issue_read(input logic [15:0] a);
    exp_rd.push_back(a);
    exp_tx.push_back(model_rd(a));
    send_byte(8'h03, $urandom_range(0, 3));
    send_byte(a[15:8], $urandom_range(0, 3));
    send_byte(a[7:0], 0);
  endtask

  task automatic cmd_hold(input logic h);
    send_byte(h ? 8'h06 : 8'h07, 0);
    hold_m = h;
    check("cpu_hold_next_cycle", cpu_hold, hold_m);
  endtask

  task automatic cmd_bad(input logic [7:0] b);
    send_byte(b, 0);
    err_m = sat(err_m);
    check("err_cnt_bad_opcode", err_cnt, err_m);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] pool [8];
  logic [7:0]  bad_b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_halt_req", cpu_halt_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    rst = 1'b0;

    // Held CPU: write completes with no halt request.
    issue_write(16'h8000, 8'hA9);
    wait_done();

    // Read back through UART.
    issue_read(16'h8000);
    wait_done();
    issue_write(16'h4000, 8'h5C);
    wait_done();
    issue_read(16'h4000);
    wait_done();

    // UART busy for 50 cycles: start must wait; a byte arriving meanwhile is dropped.
    ext_busy = 1'b1;
    issue_read(16'h8000);
    repeat (10) @(posedge clk);
    send_byte(8'h02, 0);
    err_m = sat(err_m);
    check("busy_drop_err", err_cnt, err_m);
    repeat (40) @(posedge clk);
    #1 check("tx_waits_for_idle", exp_tx.size(), 1);
    ext_busy = 1'b0;
    wait_done();

    // Running CPU: halt handshake with a 20-cycle ack delay.
    cmd_hold(1'b0);
    ack_delay = 20;
    issue_write(16'h0010, 8'h33);
    check("halt_req_rises", cpu_halt_req, 1);
    check("no_we_before_ack", bus_we, 0);
    wait_done();
    ack_delay = 3;
    issue_read(16'h0010);
    wait_done();

    // Inter-byte timeout aborts; a byte just inside the window does not.
    send_byte(8'h02, 0);
    send_byte(8'h80, TIMEOUT + 5);
    err_m = sat(err_m);
    check("timeout_err", err_cnt, err_m);
    exp_rd.push_back(16'h0000);
    exp_tx.push_back(model_rd(16'h0000));
    send_byte(8'h03, TIMEOUT - 8);
    send_byte(8'h00, TIMEOUT - 8);
    send_byte(8'h00, 0);
    wait_done();

    cmd_bad(8'h55);

    // Randomized command mix.
    foreach (pool[i]) pool[i] = 16'($urandom);
    for (int it = 0; it < 40; it++) begin
      ack_delay   = $urandom_range(0, 8);
      tx_busy_len = $urandom_range(1, 12);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin issue_write(pool[$urandom_range(0, 7)], 8'($urandom)); wait_done(); end
        4, 5, 6:    begin issue_read(pool[$urandom_range(0, 7)]); wait_done(); end
        7:          cmd_hold(1'b1);
        8:          cmd_hold(1'b0);
        default: begin
          bad_b = 8'($urandom);
          if (bad_b inside {8'h02, 8'h03, 8'h06, 8'h07}) bad_b = 8'hE1;
          cmd_bad(bad_b);
        end
      endcase
    end

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hFF, 0);
      err_m = sat(err_m);
    end
    check("err_cnt_saturates", err_cnt, 8'hFF);

    // Reset in the middle of a write: no strobe, everything back to reset values.
    cmd_hold(1'b1);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = 8'h56;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_cpu_hold", cpu_hold, 1);
    check("rst2_bus_we", bus_we, 0);
    check("rst2_bus_sel", bus_sel, 0);
    check("rst2_err_cnt", err_cnt, 0);
    check("rst2_bus_addr", bus_addr, 0);
    check("rst2_bus_wdata", bus_wdata, 0);
    check("rst2_tx_data", tx_data, 0);
    check("rst2_halt_req", cpu_halt_req | bus_re | tx_start, 0);
    rst = 1'b0;
    err_m  = 8'h00;
    hold_m = 1'b1;

    issue_read(16'h8000);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
